// File: rtl/change_event_logger_if.sv
// Event read port of change_event_logger: show-ahead ready/valid stream of
// {timestamp, value} records.
interface change_event_logger_if #(
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DATA_W = 6
);
  logic              ev_valid;
  logic              ev_ready;
  logic [TS_W-1:0]   ev_time;
  logic [DATA_W-1:0] ev_data;

  modport master (
    output ev_valid,
    output ev_time,
    output ev_data,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_time,
    input  ev_data,
    output ev_ready
  );
endinterface

// File: rtl/change_event_logger.sv
// Change monitor: logs {timestamp, value} whenever sig_in differs from the
// previous sample (plus the first sample after reset) into a show-ahead FIFO.
module change_event_logger #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    sig_in,
  change_event_logger_if.master ev,
  output logic                 ovf,
  output logic [CNT_W-1:0]     drop_cnt,
  input  logic                 ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic {
    ST_ARMED,
    ST_RUN
  } state_e;

  state_e            state_q;
  logic [TS_W-1:0]   ts_q;
  logic [DATA_W-1:0] prev_q;

  logic [TS_W-1:0]   mem_ts  [DEPTH];
  logic [DATA_W-1:0] mem_dat [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q,  count_d;
  logic              valid_q,  valid_d;
  logic [TS_W-1:0]   hd_ts_q,  hd_ts_d;
  logic [DATA_W-1:0] hd_dat_q, hd_dat_d;
  logic              ovf_q,    ovf_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;

  logic push, pop, full, wr_en, drop;

  always_comb begin
    push  = (state_q == ST_ARMED) || (sig_in != prev_q);
    full  = (count_q == FULL_LVL);
    pop   = valid_q && ev.ev_ready;
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;

    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - (AW+1)'(1);
    end
    valid_d = (count_d != '0);

    // Head register: the next head is the entry being written this edge when
    // it lands exactly at the new read pointer, otherwise it is already in memory.
    // Holds the last popped entry once the FIFO drains.
    hd_ts_d  = hd_ts_q;
    hd_dat_d = hd_dat_q;
    if (valid_d) begin
      if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
        hd_ts_d  = ts_q;
        hd_dat_d = sig_in;
      end else begin
        hd_ts_d  = mem_ts[rd_ptr_d];
        hd_dat_d = mem_dat[rd_ptr_d];
      end
    end

    // A drop in the same cycle as a clear wins: counter restarts at 1.
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_clr) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ARMED;
      ts_q     <= '0;
      prev_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      hd_ts_q  <= '0;
      hd_dat_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= ST_RUN;
      ts_q     <= ts_q + TS_W'(1);
      prev_q   <= sig_in;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      hd_ts_q  <= hd_ts_d;
      hd_dat_q <= hd_dat_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_ts[wr_ptr_q]  <= ts_q;
      mem_dat[wr_ptr_q] <= sig_in;
    end
  end

  assign ev.ev_valid = valid_q;
  assign ev.ev_time  = hd_ts_q;
  assign ev.ev_data  = hd_dat_q;
  assign ovf         = ovf_q;
  assign drop_cnt    = cnt_q;

endmodule
